// File: rtl/sched_flow_queue_pkg.sv
// sched_flow_queue_pkg: write-port indexing width for the flow queue
package sched_flow_queue_pkg;
    localparam int PORT_IDX_W = 2;
endpackage

// File: rtl/tcp_pkg.sv
// tcp_pkg: flow-ID sizing shared across the scheduler
package tcp_pkg;
    localparam int FLOWID_W     = 4;
    localparam int MAX_FLOW_CNT = 1 << FLOWID_W;
endpackage

// File: rtl/sched_flow_queue_dedup_filter.sv
// sched_dedup_filter: resident-flow bitmap, same-cycle duplicate resolution and drop counter
module sched_dedup_filter
    import tcp_pkg::*;
    import sched_flow_queue_pkg::*;
#(
    parameter int NUM_WR_PORTS = 2,
    parameter int DEDUP_EN     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_WR_PORTS-1:0]          wr_valid,
    input  logic [NUM_WR_PORTS*FLOWID_W-1:0] wr_flowid,
    input  logic                             rd_fire,
    input  logic [FLOWID_W-1:0]              rd_flowid,
    output logic [NUM_WR_PORTS-1:0]          accept,
    output logic [15:0]                      dup_drop_cnt
);
    if (DEDUP_EN != 0) begin : g_dedup
        logic [MAX_FLOW_CNT-1:0] resident;
        logic [MAX_FLOW_CNT-1:0] resident_nxt;
        logic [PORT_IDX_W:0]     n_dup;
        logic [16:0]             cnt_sum;
        // Read releases its flow first; each accepted write marks its flow so higher ports see it as resident
        always_comb begin
            resident_nxt = resident;
            if (rd_fire) resident_nxt[rd_flowid] = 1'b0;
            accept = '0;
            n_dup  = '0;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_valid[p]) begin
                    if (resident_nxt[wr_flowid[p*FLOWID_W +: FLOWID_W]]) begin
                        n_dup = n_dup + (PORT_IDX_W+1)'(1);
                    end else begin
                        accept[p] = 1'b1;
                        resident_nxt[wr_flowid[p*FLOWID_W +: FLOWID_W]] = 1'b1;
                    end
                end
            end
            cnt_sum = {1'b0, dup_drop_cnt} + 17'(n_dup);
        end
        // Bitmap and saturating duplicate counter
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                resident     <= '0;
                dup_drop_cnt <= '0;
            end else begin
                resident     <= resident_nxt;
                dup_drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
        end
    end else begin : g_plain
        assign accept       = wr_valid;
        assign dup_drop_cnt = '0;
    end
endmodule

// File: rtl/sched_flow_queue.sv
// sched_flow_queue: multi-port FWFT flow-ID queue with optional deduplication
module sched_flow_queue
    import tcp_pkg::*;
    import sched_flow_queue_pkg::*;
#(
    parameter int NUM_WR_PORTS = 2,
    parameter int DEPTH        = MAX_FLOW_CNT,
    parameter int DEDUP_EN     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_WR_PORTS-1:0]          wr_req,
    input  logic [NUM_WR_PORTS*FLOWID_W-1:0] wr_flowid,
    output logic                             wr_full,
    input  logic                             rd_req,
    output logic [FLOWID_W-1:0]              rd_flowid,
    output logic                             rd_empty,
    output logic [$clog2(DEPTH):0]           occupancy,
    output logic [15:0]                      dup_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLOWID_W-1:0]     mem [DEPTH];
    logic [AW-1:0]           head;
    logic [AW-1:0]           tail;
    logic [AW-1:0]           wr_off [NUM_WR_PORTS];
    logic [CW-1:0]           n_acc;
    logic [NUM_WR_PORTS-1:0] accept;
    logic                    rd_fire;

    assign rd_empty  = occupancy == '0;
    assign wr_full   = occupancy > CW'(DEPTH - NUM_WR_PORTS);
    assign rd_fire   = rd_req && !rd_empty;
    assign rd_flowid = rd_empty ? '0 : mem[head];

    sched_dedup_filter #(
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .DEDUP_EN     (DEDUP_EN)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_req & {NUM_WR_PORTS{~wr_full}}),
        .wr_flowid    (wr_flowid),
        .rd_fire      (rd_fire),
        .rd_flowid    (rd_flowid),
        .accept       (accept),
        .dup_drop_cnt (dup_drop_cnt)
    );

    // Accepted ports pack contiguously at the tail in ascending port order
    always_comb begin
        n_acc = '0;
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            wr_off[p] = n_acc[AW-1:0];
            n_acc     = n_acc + CW'(accept[p]);
        end
    end

    // Entry storage; contents beyond the occupied window are don't-care
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (accept[p]) mem[tail + wr_off[p]] <= wr_flowid[p*FLOWID_W +: FLOWID_W];
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks writes minus valid reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head + AW'(rd_fire);
            tail      <= tail + n_acc[AW-1:0];
            occupancy <= occupancy + n_acc - CW'(rd_fire);
        end
    end
endmodule

// File: tb/tb_sched_flow_queue.sv
// tb_sched_flow_queue: queue-model checking of a dedup instance and a small plain-FIFO instance
module tb_sched_flow_queue;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] wr_req [2];
    logic [7:0] wr_id [2];
    logic       rd_req [2];
    logic [3:0] rd_flowid [2];
    logic       rd_empty [2];
    logic       wr_full [2];
    logic [4:0] occ0;
    logic [3:0] occ1;
    logic [15:0] dup0;
    logic [15:0] dup1;

    int vectors = 0;
    int miscompares = 0;
    int mq [2][$];
    int mcnt [2];
    bit armed = 0;

    always #5 clk = ~clk;

    sched_flow_queue u0 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req[0]), .wr_flowid(wr_id[0]), .wr_full(wr_full[0]),
        .rd_req(rd_req[0]), .rd_flowid(rd_flowid[0]), .rd_empty(rd_empty[0]),
        .occupancy(occ0), .dup_drop_cnt(dup0)
    );

    sched_flow_queue #(.NUM_WR_PORTS(2), .DEPTH(8), .DEDUP_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req[1]), .wr_flowid(wr_id[1]), .wr_full(wr_full[1]),
        .rd_req(rd_req[1]), .rd_flowid(rd_flowid[1]), .rd_empty(rd_empty[1]),
        .occupancy(occ1), .dup_drop_cnt(dup1)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: an ordered list of resident flows; full is judged on the pre-edge size,
    // the read leaves first, then ports 0..1 join if not already present (dedup instance only)
    always @(posedge clk) begin
        bit full;
        bit hit;
        int id;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mq[d].delete();
                mcnt[d] = 0;
            end else begin
                full = mq[d].size() > ((d == 0) ? 14 : 6);
                if (rd_req[d] && mq[d].size() > 0) void'(mq[d].pop_front());
                for (int p = 0; p < 2; p++) begin
                    if (wr_req[d][p] && !full) begin
                        id  = int'(wr_id[d][p*4 +: 4]);
                        hit = 0;
                        for (int i = 0; i < mq[d].size(); i++) if (mq[d][i] == id) hit = 1;
                        if (d == 0 && hit) mcnt[d] = (mcnt[d] == 65535) ? 65535 : mcnt[d] + 1;
                        else mq[d].push_back(id);
                    end
                end
            end
        end
        if (!rst_n) armed = 1;
    end

    // Every cycle once reset has been seen, both instances must match the reference
    always @(negedge clk) begin
        int n;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                n = mq[d].size();
                chk($sformatf("d%0d_empty", d), 32'(rd_empty[d]), 32'(n == 0));
                chk($sformatf("d%0d_flowid", d), 32'(rd_flowid[d]), (n == 0) ? 0 : mq[d][0]);
                chk($sformatf("d%0d_occ", d), (d == 0) ? 32'(occ0) : 32'(occ1), n);
                chk($sformatf("d%0d_full", d), 32'(wr_full[d]), 32'(n > ((d == 0) ? 14 : 6)));
                chk($sformatf("d%0d_dup", d), (d == 0) ? 32'(dup0) : 32'(dup1), mcnt[d]);
            end
        end
    end

    task automatic step(int d, logic [1:0] r, logic [3:0] a, logic [3:0] b, logic rd);
        for (int k = 0; k < 2; k++) begin
            wr_req[k] = '0;
            wr_id[k]  = '0;
            rd_req[k] = 1'b0;
        end
        wr_req[d] = r;
        wr_id[d]  = {b, a};
        rd_req[d] = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 2'b01, 4'd5, 4'd0, 1'b1);
        step(0, 2'b11, 4'd5, 4'd6, 1'b0);
        chk("rst_empty", 32'(rd_empty[0]), 1);
        chk("rst_occ", 32'(occ0), 0);
        chk("rst_full", 32'(wr_full[0]), 0);
        chk("rst_flowid", 32'(rd_flowid[0]), 0);
        chk("rst_dup", 32'(dup0), 0);
        rst_n = 1'b1;
        step(0, 2'b01, 4'd5, 4'd0, 1'b0);
        chk("w5_flowid", 32'(rd_flowid[0]), 5);
        chk("w5_occ", 32'(occ0), 1);
        chk("w5_empty", 32'(rd_empty[0]), 0);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        chk("rd_on_empty_occ", 32'(occ0), 0);
        step(0, 2'b11, 4'd3, 4'd7, 1'b0);
        chk("pair_head", 32'(rd_flowid[0]), 3);
        chk("pair_occ", 32'(occ0), 2);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        chk("pair_second", 32'(rd_flowid[0]), 7);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        step(0, 2'b01, 4'd4, 4'd0, 1'b0);
        step(0, 2'b10, 4'd0, 4'd4, 1'b0);
        chk("dup_occ", 32'(occ0), 1);
        chk("dup_cnt", 32'(dup0), 1);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        step(0, 2'b11, 4'd9, 4'd6, 1'b0);
        step(0, 2'b01, 4'd9, 4'd0, 1'b1);
        chk("rewrite_occ", 32'(occ0), 2);
        chk("rewrite_head", 32'(rd_flowid[0]), 6);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        chk("rewrite_tail", 32'(rd_flowid[0]), 9);
        step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(0, 2'b11, 4'(2*i), 4'(2*i+1), 1'b0);
            if (i == 6) chk("fill14_full", 32'(wr_full[0]), 0);
        end
        chk("fill16_full", 32'(wr_full[0]), 1);
        step(0, 2'b11, 4'd0, 4'd1, 1'b0);
        chk("full_drop_occ", 32'(occ0), 16);
        for (int i = 0; i < 16; i++) step(0, 2'b00, 4'd0, 4'd0, 1'b1);
        step(0, 2'b11, 4'd2, 4'd2, 1'b0);
        chk("same2_occ", 32'(occ0), 1);
        chk("same2_dup", 32'(dup0), 2);
        rst_n = 1'b0;
        step(0, 2'b00, 4'd0, 4'd0, 1'b0);
        chk("midrst_empty", 32'(rd_empty[0]), 1);
        chk("midrst_dup", 32'(dup0), 0);
        rst_n = 1'b1;
        step(0, 2'b01, 4'd2, 4'd0, 1'b0);
        chk("after_rst_accept", 32'(occ0), 1);
        step(1, 2'b11, 4'd1, 4'd1, 1'b0);
        step(1, 2'b11, 4'd2, 4'd3, 1'b0);
        step(1, 2'b11, 4'd4, 4'd5, 1'b0);
        chk("fifo6_full", 32'(wr_full[1]), 0);
        step(1, 2'b01, 4'd6, 4'd0, 1'b0);
        chk("fifo7_full", 32'(wr_full[1]), 1);
        step(1, 2'b01, 4'd15, 4'd0, 1'b0);
        chk("fifo_drop_occ", 32'(occ1), 7);
        for (int i = 0; i < 20; i++) step(1, 2'b01, 4'(i), 4'd0, 1'b1);
        chk("wrap_occ", 32'(occ1), 6);
        chk("wrap_head", 32'(rd_flowid[1]), 14);
        for (int i = 0; i < 8; i++) step(1, 2'b00, 4'd0, 4'd0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sched_flow_queue.md
SCHED_FLOW_QUEUE -- requirements
Module: sched_flow_queue

Interface
REQ-001 Parameter NUM_WR_PORTS, default 2: number of independent flow-ID write ports, 1..4.
REQ-002 Parameter DEPTH, default MAX_FLOW_CNT: entry count, power of two.
REQ-003 Parameter DEDUP_EN, default 1: 1 = a flow ID may be resident at most once; 0 = plain multi-write FIFO.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 wr_req  in  NUM_WR_PORTS  per-port enqueue request.
REQ-007 wr_flowid  in  NUM_WR_PORTS*FLOWID_W  per-port flow ID; port p occupies bits [p*FLOWID_W +: FLOWID_W].
REQ-008 wr_full  out  1  when high, the queue cannot guarantee space for NUM_WR_PORTS writes.
REQ-009 rd_req  in  1  dequeue the head entry.
REQ-010 rd_flowid  out  FLOWID_W  head flow ID; valid while rd_empty is low.
REQ-011 rd_empty  out  1  queue holds no entries.
REQ-012 occupancy  out  clog2(DEPTH)+1  current entry count.
REQ-013 dup_drop_cnt  out  16  saturating count of writes suppressed by deduplication.

Function
REQ-014 Head read is first-word fall-through: rd_flowid shows the oldest entry combinationally from the registered head, with zero read latency.
REQ-015 A write accepted at edge N is visible at the head no earlier than edge N+1; there is no write-to-read bypass.
REQ-016 Writes accepted in the same cycle are enqueued in ascending port order: port 0 first.
REQ-017 wr_full is registered-state-derived: high when occupancy > DEPTH - NUM_WR_PORTS.
REQ-018 A write presented while wr_full is high is dropped, and the queue state is unchanged for that port.
REQ-019 rd_req while rd_empty is high is ignored: no pointer or occupancy change.
REQ-020 Pointers wrap modulo DEPTH; occupancy = previous + accepted writes - (1 if a valid read occurs).
REQ-021 With DEDUP_EN=1, a MAX_FLOW_CNT-bit resident bitmap tracks queued flows: the bit is set on enqueue and cleared on dequeue.
REQ-022 With DEDUP_EN=1, a write whose flow bit is already set is dropped, and dup_drop_cnt increments by 1 per dropped write, saturating at 0xFFFF.
REQ-023 With DEDUP_EN=1, same-cycle writes of one flow ID on several ports accept only the lowest-numbered port; the others count as duplicates.
REQ-024 With DEDUP_EN=1, when a flow is read and written in the same cycle, the read clears the bit first, so the write is accepted and re-enqueued at the tail.
REQ-025 With DEDUP_EN=1 and DEPTH >= MAX_FLOW_CNT, overflow is impossible; wr_full is still generated per REQ-017.
REQ-026 With DEDUP_EN=0, the bitmap is not instantiated, dup_drop_cnt is tied to 0, and duplicates are enqueued.

Reset
REQ-027 While rst_n is low at a clock edge, the following are zeroed: head pointer, tail pointer, occupancy, resident bitmap and dup_drop_cnt.
REQ-028 Output reset values are: rd_empty=1, wr_full=0, occupancy=0, dup_drop_cnt=0, rd_flowid=0.
REQ-029 Requests coincident with reset are discarded; reset mid-operation discards all queued entries.

Structure
REQ-030 FLOWID_W and MAX_FLOW_CNT come from tcp_pkg; no new package typedefs are needed beyond an optional port-index width constant.
REQ-031 Storage is a flop array of DEPTH x FLOWID_W, with NUM_WR_PORTS write-address offsets computed from the prefix count of accepted lower ports.
REQ-032 A sub-module, sched_dedup_filter, holds the bitmap, resolves same-cycle duplicates and produces the per-port accept vector.

Verification
REQ-033 Reset, then write flow 5 on port 0 -> next cycle rd_empty=0, rd_flowid=5, occupancy=1.
REQ-034 Same cycle: port0=3, port1=7 -> reads return 3 then 7; occupancy goes 2,1,0.
REQ-035 Flow 4 resident; write 4 on port 1 -> dropped, occupancy unchanged, dup_drop_cnt=1.
REQ-036 Head=9 with rd_req=1 and a write of 9 in the same cycle -> 9 re-enqueued at the tail, occupancy unchanged.
REQ-037 DEPTH=8, NUM_WR_PORTS=2, DEDUP_EN=0; fill to 7 -> wr_full=1 and a further write is dropped; 20 enqueue/dequeue cycles confirm pointer wrap preserves order.
REQ-038 Both ports write flow 2 in the same cycle -> one entry only, dup_drop_cnt=1; then assert rst_n=0 -> rd_empty=1 and the bitmap is cleared (a new write of 2 is accepted).
